retire_trace_buffer: RTL and testbench
======================================

# retire_trace_buffer

Synthesizable commit-trace unit downstream of the pipeline's write-back stage. It shadows the issue-stage instruction through EX/MEM/WB and, on each retirement, captures a record: PC, instruction, register indices, type, and post-write register-file values. Records go into a FIFO that a checker, DPI bridge or debug port drains with a valid/ready handshake. This replaces free-running behavioural shadow pipelines with one stall-aware, lossless-or-flagged trace source.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pipe_en`  in  1  pipeline advance; shadow stages shift only when high.
- `pc_iss`  in  32  PC of the instruction in ISS.
- `instr_iss`  in  32  instruction word in ISS.
- `rd_iss`, `rs1_iss`, `rs2_iss`  in  5 each  decoded register indices.
- `is_r_type_iss` … `is_j_type_iss`  in  1 each  six one-hot decode flags (R, I, S, B, U, J).
- `instr_retired`  in  1  WB retires the shadowed WB instruction this cycle.
- `wb_rd`, `wb_rs1`, `wb_rs2`  out  5 each  register-file read addresses; the current WB shadow indices.
- `rf_rd_val`, `rf_rs1_val`, `rf_rs2_val`  in  32 each  register-file values at those addresses. Combinational return, valid in the same cycle.
- `trace_valid`  out  1  FIFO head holds a record.
- `trace_ready`  in  1  consumer accepts the head.
- `trace_pc`, `trace_instr`  out  32 each  head record fields.
- `trace_rd`, `trace_rs1`, `trace_rs2`  out  5 each.
- `trace_type`  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=none.
- `trace_rd_val`, `trace_rs1_val`, `trace_rs2_val`  out  32 each.
- `retire_count`  out  32  number of retirements seen.
- `overflow`  out  1  sticky; at least one record was dropped.

## Operation
- **Shadow pipeline.** Three register stages: EX, MEM, WB.
  - On a rising edge with `pipe_en`=1: ISS→EX, EX→MEM, MEM→WB.
  - With `pipe_en`=0: all stages hold.
- **Type encoding.** Performed at ISS→EX capture.
  - Priority when several flags are set: R>I>S>B>U>J.
  - No flag set encodes 7.
- **Retirement.** On a rising edge with `instr_retired`=1, one record is formed:
  - WB shadow fields.
  - `rf_*_val` as sampled at that edge.
- **Retire counter.** `retire_count` increments by 1 per retirement and wraps 0xFFFFFFFF→0.
- **FIFO push.** Push the record if the FIFO is not full, or if it is full and a pop occurs on the same edge.
- **Overflow.** If the FIFO is full and no pop occurs, the record is discarded and `overflow` sets. `overflow` clears only on reset.
- **Pop.** A pop occurs on an edge with `trace_valid`=1 and `trace_ready`=1. `trace_*` is stable while `trace_valid`=1 and `trace_ready`=0.
- **FIFO structure.** Read/write pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the pointers differ only in the MSB.
- **Register x0.** No special handling: x0 values come from the register file as-is.

## Timing
- **Reset values.** All outputs, shadow registers and FIFO pointers are 0. Exceptions:
  - `trace_type` is 0.
  - Shadow stage type registers are 7.
- **ISS to WB.** An instruction present at ISS reaches the WB shadow after 3 edges with `pipe_en`=1.
- **Retire to visibility.** A retirement at edge N into an empty FIFO gives `trace_valid`=1 from edge N onward. The head is registered, so the record is visible in the cycle after edge N.
- **Throughput.** One push and one pop per cycle. Push and pop on the same edge leave occupancy unchanged.
- **Retirement while stalled.** An `instr_retired` pulse while `pipe_en`=0 still captures the current WB shadow.
- **Mid-operation reset.** Asserting `reset` at any time:
  - flushes the FIFO and shadow stages;
  - drops `trace_valid` immediately (asynchronously);
  - clears `retire_count` and `overflow`.

## Configuration
- **`RETIRE_TRACE_TIMESTAMP_EN` defined:**
  - a free-running 32-bit cycle counter, reset 0 and wrapping;
  - its value at the retirement edge is stored in each record;
  - the stored value is presented on the extra output `trace_cycle` (32 bits).
- **Undefined:** no counter, no `trace_cycle` port, and a narrower FIFO entry.

## Test plan
- **Single retire.** Reset, then drive ISS with pc=0x100, instr=0x00500093, I-type, rd=1 and rs1=0. Run 3 edges with `pipe_en` high, then pulse `instr_retired` with `rf_rd_val`=5 and `trace_ready`=1. Required: next cycle `trace_valid`=1, `trace_pc`=0x100, `trace_type`=1, `trace_rd_val`=5, `retire_count`=1.
- **Stall.** Hold `pipe_en`=0 for 4 cycles mid-stream. Required: WB shadow unchanged, and records emerge in program order with no duplicate or skipped PC.
- **Overflow.** DEPTH=8 with `trace_ready`=0 and 9 retirements. Required: the 9th is dropped and `overflow`=1. Then raise `trace_ready`: exactly 8 records drain, first to eighth in order.
- **Full FIFO, simultaneous push and pop.** Required: the record is accepted, occupancy stays 8, and `overflow` stays 0.
- **Reset mid-operation.** With 3 records queued, pulse `reset` low. Required: `trace_valid`=0 immediately, `retire_count`=0, `overflow`=0.
- **Timestamp build.** With `RETIRE_TRACE_TIMESTAMP_EN`, retire on cycles 10 and 14 after reset. Required: `trace_cycle` differs by 4 between the two records.

Source files
------------

// File: rtl/retire_trace_buffer_if.sv
// Trace record stream from the retire buffer to its consumer (checker, bridge, debug port).
// Define RETIRE_TRACE_TIMESTAMP_EN to add the per-record cycle stamp.
interface retire_trace_buffer_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic [4:0]  trace_rd;
    logic [4:0]  trace_rs1;
    logic [4:0]  trace_rs2;
    logic [2:0]  trace_type;
    logic [31:0] trace_rd_val;
    logic [31:0] trace_rs1_val;
    logic [31:0] trace_rs2_val;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] trace_cycle;
`endif

    modport master (
        output trace_valid, trace_pc, trace_instr, trace_rd, trace_rs1, trace_rs2,
               trace_type, trace_rd_val, trace_rs1_val, trace_rs2_val,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
               trace_cycle,
`endif
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_pc, trace_instr, trace_rd, trace_rs1, trace_rs2,
               trace_type, trace_rd_val, trace_rs1_val, trace_rs2_val,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
               trace_cycle,
`endif
        output trace_ready
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Commit-trace unit: shadows ISS->EX->MEM->WB and queues one record per retirement (RETIRE_TRACE_TIMESTAMP_EN adds cycle stamp).
// Latency: ISS reaches WB shadow after 3 enabled edges; a retired record is visible the cycle after the retire edge.
// Backpressure: DEPTH-entry FIFO drained by valid/ready; retiring into a full FIFO with no pop drops the record and sets sticky overflow.
module retire_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_en,
    input  logic [31:0] pc_iss,
    input  logic [31:0] instr_iss,
    input  logic [4:0]  rd_iss,
    input  logic [4:0]  rs1_iss,
    input  logic [4:0]  rs2_iss,
    input  logic        is_r_type_iss,
    input  logic        is_i_type_iss,
    input  logic        is_s_type_iss,
    input  logic        is_b_type_iss,
    input  logic        is_u_type_iss,
    input  logic        is_j_type_iss,
    input  logic        instr_retired,
    output logic [4:0]  wb_rd,
    output logic [4:0]  wb_rs1,
    output logic [4:0]  wb_rs2,
    input  logic [31:0] rf_rd_val,
    input  logic [31:0] rf_rs1_val,
    input  logic [31:0] rf_rs2_val,
    retire_trace_buffer_if.master trace,
    output logic [31:0] retire_count,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  ty;
    } shadow_t;

    typedef struct packed {
        shadow_t     s;
        logic [31:0] rd_val;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
        logic [31:0] cycle;
`endif
    } rec_t;

    localparam shadow_t SHADOW_RST = '{pc: 32'd0, instr: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, ty: 3'd7};

    shadow_t     iss, ex_q, mem_q, wb_q;
    rec_t        rec;
    rec_t        mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, not_empty, pop, push;

    always_comb begin
        iss.pc    = pc_iss;
        iss.instr = instr_iss;
        iss.rd    = rd_iss;
        iss.rs1   = rs1_iss;
        iss.rs2   = rs2_iss;
        iss.ty    = 3'd7;
        if      (is_r_type_iss) iss.ty = 3'd0;
        else if (is_i_type_iss) iss.ty = 3'd1;
        else if (is_s_type_iss) iss.ty = 3'd2;
        else if (is_b_type_iss) iss.ty = 3'd3;
        else if (is_u_type_iss) iss.ty = 3'd4;
        else if (is_j_type_iss) iss.ty = 3'd5;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= SHADOW_RST;
            mem_q <= SHADOW_RST;
            wb_q  <= SHADOW_RST;
        end else if (pipe_en) begin
            ex_q  <= iss;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign wb_rd  = wb_q.rd;
    assign wb_rs1 = wb_q.rs1;
    assign wb_rs2 = wb_q.rs2;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_q <= 32'd0;
        else        cycle_q <= cycle_q + 32'd1;
    end
`endif

    // Register-file values are a combinational return for the WB indices, so they belong to this edge's record.
    always_comb begin
        rec.s       = wb_q;
        rec.rd_val  = rf_rd_val;
        rec.rs1_val = rf_rs1_val;
        rec.rs2_val = rf_rs2_val;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
        rec.cycle   = cycle_q;
`endif
    end

    assign not_empty = (wptr != rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop       = not_empty && trace.trace_ready;
    assign push      = instr_retired && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr         <= '0;
            rptr         <= '0;
            retire_count <= 32'd0;
            overflow     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= rec;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop)                             rptr         <= rptr + (AW+1)'(1);
            if (instr_retired)                   retire_count <= retire_count + 32'd1;
            if (instr_retired && full && !pop)   overflow     <= 1'b1;
        end
    end

    assign trace.trace_valid   = not_empty;
    assign trace.trace_pc      = mem[rptr[AW-1:0]].s.pc;
    assign trace.trace_instr   = mem[rptr[AW-1:0]].s.instr;
    assign trace.trace_rd      = mem[rptr[AW-1:0]].s.rd;
    assign trace.trace_rs1     = mem[rptr[AW-1:0]].s.rs1;
    assign trace.trace_rs2     = mem[rptr[AW-1:0]].s.rs2;
    assign trace.trace_type    = mem[rptr[AW-1:0]].s.ty;
    assign trace.trace_rd_val  = mem[rptr[AW-1:0]].rd_val;
    assign trace.trace_rs1_val = mem[rptr[AW-1:0]].rs1_val;
    assign trace.trace_rs2_val = mem[rptr[AW-1:0]].rs2_val;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    assign trace.trace_cycle   = mem[rptr[AW-1:0]].cycle;
`endif
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed table, corner sequences, and a randomized run against a queue-based model.
module tb_retire_trace_buffer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_en;
    logic [31:0] pc_iss, instr_iss;
    logic [4:0]  rd_iss, rs1_iss, rs2_iss;
    logic [5:0]  flags;
    logic        instr_retired;
    logic [4:0]  wb_rd, wb_rs1, wb_rs2;
    logic [31:0] rf_rd_val, rf_rs1_val, rf_rs2_val;
    logic [31:0] retire_count;
    logic        overflow;
    logic [31:0] rf [32];

    retire_trace_buffer_if tif ();

    retire_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pipe_en(pipe_en),
        .pc_iss(pc_iss), .instr_iss(instr_iss),
        .rd_iss(rd_iss), .rs1_iss(rs1_iss), .rs2_iss(rs2_iss),
        .is_r_type_iss(flags[5]), .is_i_type_iss(flags[4]), .is_s_type_iss(flags[3]),
        .is_b_type_iss(flags[2]), .is_u_type_iss(flags[1]), .is_j_type_iss(flags[0]),
        .instr_retired(instr_retired),
        .wb_rd(wb_rd), .wb_rs1(wb_rs1), .wb_rs2(wb_rs2),
        .rf_rd_val(rf_rd_val), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .trace(tif), .retire_count(retire_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign rf_rd_val  = rf[wb_rd];
    assign rf_rs1_val = rf[wb_rs1];
    assign rf_rs2_val = rf[wb_rs2];

    typedef struct {
        logic [31:0] pc, instr;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  ty;
    } sh_t;
    typedef struct {
        sh_t         s;
        logic [31:0] rdv, rs1v, rs2v;
    } mrec_t;

    sh_t         hist [$];
    mrec_t       q [$];
    logic [31:0] m_cnt;
    logic        m_ovf;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] enc_type(input logic [5:0] f);
        for (int k = 0; k < 6; k++)
            if (f[5-k]) return 3'(k);
        return 3'd7;
    endfunction

    // WB holds whatever entered ISS three enabled edges ago, else the reset shadow.
    function automatic sh_t m_wb();
        sh_t r;
        r = '{pc: 0, instr: 0, rd: 0, rs1: 0, rs2: 0, ty: 3'd7};
        if (hist.size() == 3) r = hist[0];
        return r;
    endfunction

    task automatic model_edge();
        sh_t   w, cur;
        mrec_t r;
        bit    pop, full;
        w    = m_wb();
        pop  = (q.size() != 0) && tif.trace_ready;
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (instr_retired) begin
            m_cnt = m_cnt + 32'd1;
            r.s = w; r.rdv = rf[w.rd]; r.rs1v = rf[w.rs1]; r.rs2v = rf[w.rs2];
            if (full && !pop) m_ovf = 1'b1;
            else              q.push_back(r);
        end
        if (pipe_en) begin
            cur = '{pc: pc_iss, instr: instr_iss, rd: rd_iss, rs1: rs1_iss, rs2: rs2_iss, ty: enc_type(flags)};
            hist.push_back(cur);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic check_all();
        sh_t w;
        w = m_wb();
        check("valid", 64'(tif.trace_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("pc",      64'(tif.trace_pc),      64'(q[0].s.pc));
            check("instr",   64'(tif.trace_instr),   64'(q[0].s.instr));
            check("rd",      64'(tif.trace_rd),      64'(q[0].s.rd));
            check("rs1",     64'(tif.trace_rs1),     64'(q[0].s.rs1));
            check("rs2",     64'(tif.trace_rs2),     64'(q[0].s.rs2));
            check("type",    64'(tif.trace_type),    64'(q[0].s.ty));
            check("rd_val",  64'(tif.trace_rd_val),  64'(q[0].rdv));
            check("rs1_val", 64'(tif.trace_rs1_val), 64'(q[0].rs1v));
            check("rs2_val", 64'(tif.trace_rs2_val), 64'(q[0].rs2v));
        end
        check("wb_rd",  64'(wb_rd),  64'(w.rd));
        check("wb_rs1", 64'(wb_rs1), 64'(w.rs1));
        check("wb_rs2", 64'(wb_rs2), 64'(w.rs2));
        check("retire_count", 64'(retire_count), 64'(m_cnt));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic model_clear();
        hist.delete(); q.delete(); m_cnt = 0; m_ovf = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          pe, ret, rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_type;
        logic [31:0] exp_rdv;
        logic [4:0]  exp_wb_rd;
        logic [31:0] exp_cnt;
    } vec_t;

    initial begin
        vec_t        vt [5];
        logic [31:0] last_val, cyc1;
        int          n;

        reset = 1'b0; pipe_en = 0; instr_retired = 0; tif.trace_ready = 0;
        pc_iss = 0; instr_iss = 0; rd_iss = 0; rs1_iss = 0; rs2_iss = 0; flags = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        m_cnt = 0; m_ovf = 0;
        #1;
        check("rst_valid", 64'(tif.trace_valid), 64'd0);
        check("rst_pc",    64'(tif.trace_pc),    64'd0);
        check("rst_type",  64'(tif.trace_type),  64'd0);
        check("rst_count", 64'(retire_count),    64'd0);
        check("rst_ovf",   64'(overflow),        64'd0);
        do_reset();

        // single retire: I-type addi x1,x0,5 at 0x100
        vt[0] = '{1, 0, 1, 0, 0,      0, 0, 5'd0, 0};
        vt[1] = '{1, 0, 1, 0, 0,      0, 0, 5'd0, 0};
        vt[2] = '{1, 0, 1, 0, 0,      0, 0, 5'd1, 0};
        vt[3] = '{0, 1, 1, 1, 32'h100, 1, 5, 5'd1, 1};
        vt[4] = '{0, 0, 1, 0, 0,      0, 0, 5'd1, 1};
        pc_iss = 32'h100; instr_iss = 32'h0050_0093; rd_iss = 1; rs1_iss = 0; rs2_iss = 0;
        flags = 6'b010000; rf[1] = 32'd5;
        for (int i = 0; i < 5; i++) begin
            pipe_en = vt[i].pe; instr_retired = vt[i].ret; tif.trace_ready = vt[i].rdy;
            tick();
            check("tbl_valid", 64'(tif.trace_valid), 64'(vt[i].exp_valid));
            check("tbl_wb_rd", 64'(wb_rd), 64'(vt[i].exp_wb_rd));
            check("tbl_count", 64'(retire_count), 64'(vt[i].exp_cnt));
            if (vt[i].exp_valid) begin
                check("tbl_pc",   64'(tif.trace_pc),     64'(vt[i].exp_pc));
                check("tbl_type", 64'(tif.trace_type),   64'(vt[i].exp_type));
                check("tbl_rdv",  64'(tif.trace_rd_val), 64'(vt[i].exp_rdv));
            end
        end

        // overflow: 9 retirements into a stalled consumer, then drain exactly 8
        do_reset();
        pipe_en = 0; tif.trace_ready = 0;
        for (int i = 1; i <= 9; i++) begin
            rf[0] = 32'(i); instr_retired = 1;
            tick();
            if (i == 8) check("ovf_before", 64'(overflow), 64'd0);
        end
        check("ovf_set", 64'(overflow), 64'd1);
        instr_retired = 0; tif.trace_ready = 1;
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", 64'(tif.trace_valid), 64'd1);
            check("drain_order", 64'(tif.trace_rd_val), 64'(k + 1));
            tick();
        end
        check("drain_empty", 64'(tif.trace_valid), 64'd0);

        // full FIFO with simultaneous push and pop
        do_reset();
        pipe_en = 0; tif.trace_ready = 0;
        for (int i = 0; i < 8; i++) begin
            rf[0] = 32'(10 + i); instr_retired = 1;
            tick();
        end
        rf[0] = 32'd99; tif.trace_ready = 1;
        tick();
        check("pp_ovf",  64'(overflow), 64'd0);
        check("pp_head", 64'(tif.trace_rd_val), 64'd11);
        instr_retired = 0; n = 0; last_val = 0;
        while (tif.trace_valid && n < 20) begin
            last_val = tif.trace_rd_val;
            n++;
            tick();
        end
        check("pp_occupancy", 64'(n), 64'd8);
        check("pp_last", 64'(last_val), 64'd99);

        // asynchronous reset with records queued and overflow set
        do_reset();
        pipe_en = 1; tif.trace_ready = 0; instr_retired = 1;
        for (int i = 0; i < 9; i++) tick();
        instr_retired = 0;
        check("mr_valid_pre", 64'(tif.trace_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mr_valid", 64'(tif.trace_valid), 64'd0);
        check("mr_count", 64'(retire_count), 64'd0);
        check("mr_ovf",   64'(overflow), 64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
        do_reset();
        pipe_en = 0; tif.trace_ready = 0;
        for (int c = 1; c <= 14; c++) begin
            instr_retired = (c == 10 || c == 14);
            tick();
        end
        instr_retired = 0;
        cyc1 = tif.trace_cycle;
        tif.trace_ready = 1;
        tick();
        check("ts_delta", 64'(tif.trace_cycle - cyc1), 64'd4);
`else
        cyc1 = 0;
`endif

        // randomized run: stalls, bursts, backpressure phases, register-file churn
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            pc_iss    = 32'h1000 + 32'(c) * 4;
            instr_iss = $urandom;
            rd_iss    = 5'($urandom); rs1_iss = 5'($urandom); rs2_iss = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       flags = 6'($urandom);
                1:       flags = 6'd0;
                default: flags = 6'(1 << $urandom_range(0, 5));
            endcase
            pipe_en       = ($urandom_range(0, 3) != 0);
            instr_retired = ($urandom_range(0, 9) < 4);
            tif.trace_ready = ((c / 100) % 3 == 1) ? ($urandom_range(0, 9) == 0)
                                                   : ($urandom_range(0, 1) == 1);
            rf[$urandom_range(0, 31)] = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
